// File: rtl/mips8_pkg.sv
// Shared types and encodings for the multicycle MIPS-8 controller:
// FSM state enum, opcode constants, ALU/PC mux encodings and the control bundle.
package mips8_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUB_REGB  = 2'b00;
  localparam logic [1:0] ALUB_ONE   = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_BROFF = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full set of state-decoded control lines; pcwrite and branch stay internal
  // and are folded into pcen by the top level.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic [3:0] irwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

  // True for every opcode the controller knows how to execute.
  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LB, OP_SB: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mips8_ctrl_dec.sv
// Purely combinational Moore decode: state register -> control bundle.
// Unknown encodings decode to all-zero controls.
module mips8_ctrl_dec
  import mips8_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Map each state to its control lines; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrca  = 1'b0;
        ctrl.alusrcb  = ALUB_ONE;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.pcwrite  = 1'b1;
        ctrl.iord     = 1'b0;
        case (state)
          S_FETCH1: ctrl.irwrite = 4'b0001;
          S_FETCH2: ctrl.irwrite = 4'b0010;
          S_FETCH3: ctrl.irwrite = 4'b0100;
          S_FETCH4: ctrl.irwrite = 4'b1000;
          default:  ctrl.irwrite = 4'b0000;
        endcase
      end
      S_DECODE: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = ALUB_BROFF;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regdst   = 1'b0;
      end
      S_SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUB_REGB;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.memtoreg = 1'b0;
      end
      S_BEQEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.alusrcb  = ALUB_REGB;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.branch   = 1'b1;
        ctrl.pcsource = PCSRC_ALUOUT;
      end
      S_JEX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      S_ADDIWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b0;
        ctrl.memtoreg = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips8_ctrl.sv
// Multicycle MIPS-8 main controller: state register, next-state logic,
// illegal-opcode pulse and PC-enable gating. Control lines are a Moore
// decode of the state register (mips8_ctrl_dec).
module mips8_ctrl
  import mips8_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal_op
);

  state_t state_r;
  logic   illegal_r;
  ctrl_t  ctrl_s;

  // State register and illegal-opcode flag; reset drops straight into FETCH1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_FETCH1;
      illegal_r <= 1'b0;
    end else begin
      // Pulse during the FETCH1 that follows a DECODE of an unknown opcode.
      illegal_r <= (state_r == S_DECODE) && !is_legal_op(op);
      case (state_r)
        S_FETCH1:  state_r <= S_FETCH2;
        S_FETCH2:  state_r <= S_FETCH3;
        S_FETCH3:  state_r <= S_FETCH4;
        S_FETCH4:  state_r <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LB, OP_SB: state_r <= S_MEMADR;
            OP_RTYPE:     state_r <= S_RTYPEEX;
            OP_BEQ:       state_r <= S_BEQEX;
            OP_J:         state_r <= S_JEX;
            OP_ADDI:      state_r <= S_ADDIEX;
            default:      state_r <= S_FETCH1;
          endcase
        end
        S_MEMADR: begin
          // The IR is stable after FETCH4, so op can be looked at again here.
          case (op)
            OP_LB:   state_r <= S_LBRD;
            OP_SB:   state_r <= S_SBWR;
            default: state_r <= S_FETCH1;
          endcase
        end
        S_LBRD:    state_r <= S_LBWR;
        S_LBWR:    state_r <= S_FETCH1;
        S_SBWR:    state_r <= S_FETCH1;
        S_RTYPEEX: state_r <= S_RTYPEWR;
        S_RTYPEWR: state_r <= S_FETCH1;
        S_BEQEX:   state_r <= S_FETCH1;
        S_JEX:     state_r <= S_FETCH1;
        S_ADDIEX:  state_r <= S_ADDIWR;
        S_ADDIWR:  state_r <= S_FETCH1;
        default:   state_r <= S_FETCH1;
      endcase
    end
  end

  mips8_ctrl_dec u_dec (
    .state (state_r),
    .ctrl  (ctrl_s)
  );

  assign memread    = ctrl_s.memread;
  assign memwrite   = ctrl_s.memwrite;
  assign irwrite    = ctrl_s.irwrite;
  assign iord       = ctrl_s.iord;
  assign alusrca    = ctrl_s.alusrca;
  assign alusrcb    = ctrl_s.alusrcb;
  assign aluop      = ctrl_s.aluop;
  assign pcsource   = ctrl_s.pcsource;
  assign regwrite   = ctrl_s.regwrite;
  assign regdst     = ctrl_s.regdst;
  assign memtoreg   = ctrl_s.memtoreg;
  assign pcen       = ctrl_s.pcwrite | (ctrl_s.branch & zero);
  assign illegal_op = illegal_r;

endmodule
